// File: rtl/pb_cond_pkg.sv
// Shared types and constants for the pushbutton conditioner.
package pb_cond_pkg;

  localparam int NUM_PB = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } pb_state_t;

endpackage

// File: rtl/pb_debounce_channel.sv
// One pushbutton channel: two-flop synchroniser, debounce FSM, long-press timer.
//
// state        | meaning
// IDLE         | button released and stable, level 0
// PRESS_WAIT   | synchronised input high, counting stable samples before accepting press
// PRESSED      | press accepted, level 1, hold timer running
// RELEASE_WAIT | synchronised input low, counting stable samples; hold timer frozen
module pb_debounce_channel
  import pb_cond_pkg::*;
#(
  parameter int DB_CYCLES   = 50000,
  parameter int LONG_CYCLES = 10000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              sync1_q;
  logic              s_q;
  pb_state_t         state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_done_q;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic              long_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_q) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= DB_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s_q) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= PRESSED;
            db_cnt_q    <= '0;
            level_q     <= 1'b1;
            press_q     <= 1'b1;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end
        PRESSED: begin
          // The hold timer also advances on the cycle the input first drops.
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
            if (hold_cnt_q == HOLD_LAST && !long_done_q) begin
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
          if (!s_q) begin
            state_q  <= RELEASE_WAIT;
            db_cnt_q <= DB_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s_q) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/pb_conditioner.sv
// Two-channel pushbutton conditioner: maps pin and event vectors onto per-channel debouncers.
module pb_conditioner
  import pb_cond_pkg::*;
#(
  parameter int DB_CYCLES   = 50000,
  parameter int LONG_CYCLES = 10000000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release,
  output logic [NUM_PB-1:0] pb_long
);

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    pb_debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .nrst     (nrst),
      .raw_i    (pb_raw[i]),
      .level_o  (pb_level[i]),
      .press_o  (pb_press[i]),
      .release_o(pb_release[i]),
      .long_o   (pb_long[i])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench for pb_conditioner with DB_CYCLES=4, LONG_CYCLES=20.
module tb_pb_conditioner;

  localparam int DB   = 4;
  localparam int LONG = 20;
  // raw driven after the negedge of edge count c: sampled at edge c+1, event visible after edge c+2+DB
  localparam int LAT  = DB + 2;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic       clk;
  logic       nrst;
  logic [1:0] pb_raw;
  logic [1:0] pb_level;
  logic [1:0] pb_press;
  logic [1:0] pb_release;
  logic [1:0] pb_long;

  ev_t exp_q[$];
  ev_t e_m;
  logic hit_m;
  int cyc;
  int n_cmp;
  int n_fail;
  string kname[3] = '{"press", "release", "long"};

  pb_conditioner #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .pb_raw    (pb_raw),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_long   (pb_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: every observed pulse is popped against the scoreboard.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e_m = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event: ch%0d %s expected at cyc %0d, still absent at cyc %0d",
               e_m.ch, kname[e_m.kind], e_m.cyc, cyc);
    end
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < 3; k++) begin
        hit_m = (k == K_PRESS) ? pb_press[ch] : (k == K_RELEASE) ? pb_release[ch] : pb_long[ch];
        if (hit_m) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got ch%0d %s at cyc %0d, required none",
                     ch, kname[k], cyc);
          end else begin
            e_m = exp_q.pop_front();
            if (e_m.cyc != cyc || e_m.ch != ch || e_m.kind != k) begin
              n_fail++;
              $display("FAIL event_order: got ch%0d %s at cyc %0d, required ch%0d %s at cyc %0d",
                       ch, kname[k], cyc, e_m.ch, kname[e_m.kind], e_m.cyc);
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c;
    e.ch = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    int c;
    nrst   = 1'b0;
    pb_raw = 2'b11;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pb_level, pb_press, pb_release, pb_long} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {pb_level, pb_press, pb_release, pb_long});
    end
    c = cyc;
    nrst = 1'b1;
    push_ev(c + LAT, 0, K_PRESS);
    push_ev(c + LAT, 1, K_PRESS);
    wait_until(c + LAT + 2);
    n_cmp++;
    if (pb_level !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_then_press_level: got %b, required 11", pb_level);
    end
    c = cyc;
    pb_raw = 2'b00;
    push_ev(c + LAT, 0, K_RELEASE);
    push_ev(c + LAT, 1, K_RELEASE);
    wait_until(c + LAT + 3);
    n_cmp++;
    if (pb_level !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_then_release: level %b pending %0d, required level 00 pending 0",
               pb_level, exp_q.size());
    end
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    pb_raw[0] = 1'b1;
    push_ev(c + LAT, 0, K_PRESS);
    wait_until(c + LAT - 1);
    n_cmp++;
    if (pb_level !== 2'b00) begin
      n_fail++;
      $display("FAIL clean_press_early_level: got %b, required 00", pb_level);
    end
    wait_until(c + LAT + 2);
    n_cmp++;
    if (pb_level !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_press_level: got %b, required 01", pb_level);
    end
    c = cyc;
    pb_raw[0] = 1'b0;
    push_ev(c + LAT, 0, K_RELEASE);
    wait_until(c + LAT + 3);
    n_cmp++;
    if (pb_level !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clean_press_release: level %b pending %0d, required level 00 pending 0",
               pb_level, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      pb_raw[0] = pat[i];
      @(negedge clk);
    end
    pb_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pb_level !== 2'b00) begin
        n_fail++;
        $display("FAIL bounce_level: got %b at cyc %0d, required 00", pb_level, cyc);
      end
    end
  endtask

  task automatic test_long_hold();
    int c, p, d;
    c = cyc;
    p = c + LAT;
    d = p + 30;
    pb_raw[1] = 1'b1;
    push_ev(p, 1, K_PRESS);
    push_ev(p + LONG, 1, K_LONG);
    push_ev(d + LAT, 1, K_RELEASE);
    wait_until(p + LONG + 1);
    n_cmp++;
    if (pb_level !== 2'b10) begin
      n_fail++;
      $display("FAIL long_hold_level: got %b, required 10", pb_level);
    end
    wait_until(d);
    pb_raw[1] = 1'b0;
    wait_until(d + LAT + 3);
    n_cmp++;
    if (pb_level !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_hold_release: level %b pending %0d, required level 00 pending 0",
               pb_level, exp_q.size());
    end
  endtask

  task automatic test_release_bounce();
    int c, p, g, d;
    c = cyc;
    p = c + LAT;
    g = p + 7;
    d = p + 30;
    pb_raw[0] = 1'b1;
    push_ev(p, 0, K_PRESS);
    push_ev(p + LONG + 2, 0, K_LONG);
    push_ev(d + LAT, 0, K_RELEASE);
    wait_until(g);
    pb_raw[0] = 1'b0;
    repeat (2) @(negedge clk);
    pb_raw[0] = 1'b1;
    wait_until(p + LONG + 1);
    n_cmp++;
    if (pb_level !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch_level: got %b, required 01", pb_level);
    end
    wait_until(d);
    pb_raw[0] = 1'b0;
    wait_until(d + LAT + 3);
    n_cmp++;
    if (pb_level !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_release: level %b pending %0d, required level 00 pending 0",
               pb_level, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int c;
    c = cyc;
    pb_raw[0] = 1'b1;
    push_ev(c + LAT, 0, K_PRESS);
    wait_until(c + LAT + 3);
    n_cmp++;
    if (pb_level !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_pre_level: got %b, required 01", pb_level);
    end
    #2;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if (pb_level !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_async_level: got %b, required 00", pb_level);
    end
    @(negedge clk);
    pb_raw[0] = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (LONG + 10) @(negedge clk);
    n_cmp++;
    if (pb_level !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_after: level %b pending %0d, required level 00 pending 0",
               pb_level, exp_q.size());
    end
  endtask

  initial begin
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
    nrst   = 1'b0;
    pb_raw = 2'b00;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_bounce();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
